seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for NUM_DIGITS common-anode/cathode 7-segment digits sharing one segment bus.
- Latches a packed BCD word on a load strobe and scans the digits round-robin at a programmable refresh rate.
- Adds per-digit decimal points, leading-zero blanking and anti-ghost blanking at each digit switch.
- Sits between the datapath/counters and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (>=2).
- SLOT_CYCLES, 1000, clk cycles each digit stays selected (>= BLANK_CYCLES+1).
- BLANK_CYCLES, 8, cycles at the start of each slot during which all segments and anodes are inactive.
- ACTIVE_LOW, 1, 1: seg/dp/an asserted low; 0: asserted high.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- load  in  1  capture bcd_in/dp_in/lzb_en this cycle.
- bcd_in  in  4*NUM_DIGITS  packed BCD; digit 0 = bits [3:0] = least significant (rightmost).
- dp_in  in  NUM_DIGITS  decimal point per digit.
- lzb_en  in  1  leading-zero blanking enable.
- seg  out  7  segments {a,b,c,d,e,f,g}; seg[6]=a, seg[0]=g.
- dp  out  1  decimal point of the selected digit.
- an  out  NUM_DIGITS  digit enables; one-hot (in asserted polarity) or all inactive.
- slot_start  out  1  one-cycle pulse at the first cycle of each digit slot.

Behaviour:
- Reset: slot counter 0, digit index 0, held BCD = 4'hF per digit (blank), held dp = 0, held lzb = 0; seg, dp, an all inactive (all 1s when ACTIVE_LOW=1); slot_start = 0.
- Slot counter counts 0..SLOT_CYCLES-1. On wrap, the digit index advances 0,1,...,NUM_DIGITS-1,0. The counter is the only timebase; no enable input.
- All outputs are registered. Outputs at cycle t+1 are computed from the counter, index and held registers at cycle t.
- Blanking window: while counter < BLANK_CYCLES, seg, dp and an are all inactive. Otherwise an asserts only the index bit, and seg/dp show that digit.
- slot_start is high in the cycle after the counter equals 0, aligned with the registered outputs.
- Decode, active-high sense before polarity: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011. Codes 10-15 give 0000000 (blank).
- Leading-zero blanking: when held lzb=1, digit k (k>=1) is blanked if it and every higher digit hold 0. Digit 0 is never LZ-blanked.
- Any blanked digit still drives its held dp bit. The an bit stays asserted outside the blanking window.
- Load: a load high at cycle t updates the held registers at t+1. The change is visible on outputs from t+2 if that digit is selected and outside the blanking window. Load does not disturb the counter or index. Back-to-back loads: the last one wins.
- Polarity: if ACTIVE_LOW=1, seg, dp and an are inverted at the output register.
- Reset mid-scan: the next cycle returns to the reset state, and the scan restarts at digit 0, counter 0.
- Simultaneous rst and load: reset wins.

Decomposition:
- Shared package seg7_pkg holds the segment bit-index constants (SEG_A..SEG_G), SEG_BLANK, and a 10-entry digit-to-segment constant table.
- Natural sub-module: bcd7_decode. It is combinational, 4-bit code to 7-bit active-high segments, and blanks codes 10-15.
- The top module owns the counter, index, held registers, LZB logic, blanking and output registers.

Test Plan:
- Reset then idle, NUM_DIGITS=4, SLOT_CYCLES=16, BLANK_CYCLES=2: seg=7'h7F, an=4'hF, dp=1 throughout (all digits held at 0xF). slot_start pulses every 16 cycles. an goes low one-hot 1110, 1101, 1011, 0111, each for 14 cycles.
- load bcd_in=16'h1234, dp_in=4'b0100, lzb_en=0: the digit-0 slot shows seg=7'b0110011 active-high '4' (ACTIVE_LOW: 7'b1001100). The digit-2 slot shows '2' with dp=0 (lit).
- load bcd_in=16'h0050, lzb_en=1: digits 3 and 2 are blank (seg=7'h7F) with an still asserted. Digit 1 shows '5', digit 0 shows '0' (7'b0000001).
- load bcd_in=16'h0000, lzb_en=1: only digit 0 is lit, showing '0'. Same value with lzb_en=0: all four show '0'.
- load bcd_in=16'hABCD: every slot is blank. load asserted together with rst: after reset the held registers are still 0xF.
- Assert rst during the digit-2 slot: next cycle all outputs are inactive. After release the scan restarts at digit 0, and slot_start fires 1 cycle after counter 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: segment bit positions,
// the blank pattern and the BCD digit-to-segment table (active-high sense).
package seg7_pkg;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Entry n lights the segments of decimal digit n, {a,b,c,d,e,f,g}.
  localparam logic [6:0] DIGIT_SEGS [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

endpackage

// File: rtl/bcd7_decode.sv
// Combinational BCD to 7-segment decoder, active-high segments.
// Codes 10..15 decode to a blank digit.
module bcd7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (code <= 4'd9) seg = DIGIT_SEGS[code];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Round-robin scan driver for a multiplexed 7-segment display with held
// digits, decimal points, leading-zero blanking and anti-ghost blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 1000,
  parameter int BLANK_CYCLES = 8,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lzb_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    slot_start
);

  localparam int   CW  = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int   IW  = $clog2(NUM_DIGITS);
  localparam logic POL = (ACTIVE_LOW != 0);

  logic [CW-1:0]           cnt_reg;
  logic [IW-1:0]           idx_reg;
  logic [4*NUM_DIGITS-1:0] bcd_reg;
  logic [NUM_DIGITS-1:0]   dp_reg;
  logic                    lzb_reg;

  logic [3:0]            digit_code [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lz_mask;
  logic [3:0]            sel_code;
  logic [6:0]            dec_seg;
  logic                  in_blank;
  logic [6:0]            seg_next;
  logic                  dp_next;
  logic [NUM_DIGITS-1:0] an_next;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign digit_code[gi] = bcd_reg[gi*4 +: 4];
  end

  // A digit is leading-zero blanked when it and every digit above it are 0.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run   = zero_run & (digit_code[k] == 4'd0);
      lz_mask[k] = zero_run & lzb_reg;
    end
  end

  assign sel_code = digit_code[idx_reg];

  bcd7_decode u_dec (
    .code (sel_code),
    .seg  (dec_seg)
  );

  always_comb begin
    in_blank = (cnt_reg < CW'(BLANK_CYCLES));
    an_next  = in_blank ? '0 : (NUM_DIGITS'(1) << idx_reg);
    seg_next = (in_blank || lz_mask[idx_reg]) ? SEG_BLANK : dec_seg;
    dp_next  = !in_blank && dp_reg[idx_reg];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      idx_reg    <= '0;
      bcd_reg    <= '1;
      dp_reg     <= '0;
      lzb_reg    <= 1'b0;
      seg        <= {7{POL}};
      dp         <= POL;
      an         <= {NUM_DIGITS{POL}};
      slot_start <= 1'b0;
    end else begin
      if (cnt_reg == CW'(SLOT_CYCLES - 1)) begin
        cnt_reg <= '0;
        idx_reg <= (idx_reg == IW'(NUM_DIGITS - 1)) ? '0 : idx_reg + 1'b1;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (load) begin
        bcd_reg <= bcd_in;
        dp_reg  <= dp_in;
        lzb_reg <= lzb_en;
      end
      seg        <= seg_next ^ {7{POL}};
      dp         <= dp_next ^ POL;
      an         <= an_next ^ {NUM_DIGITS{POL}};
      slot_start <= (cnt_reg == '0);
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a behavioural model queues the
// expected outputs every cycle, and hand-derived spot values are checked.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int SC = 16;
  localparam int BC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [15:0]   bcd_in = '0;
  logic [3:0]    dp_in = '0;
  logic          lzb_en = 1'b0;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;
  logic          slot_start;

  seg7_scan_driver #(
    .NUM_DIGITS(ND), .SLOT_CYCLES(SC), .BLANK_CYCLES(BC), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .lzb_en(lzb_en), .seg(seg), .dp(dp), .an(an), .slot_start(slot_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       ss;
  } exp_t;

  exp_t sb [$];

  int n_vec = 0;
  int n_err = 0;

  int         m_cnt = 0;
  int         m_idx = 0;
  logic [15:0] m_bcd = 16'hFFFF;
  logic [3:0]  m_dp = '0;
  logic        m_lzb = 1'b0;

  logic [6:0] s_seg;
  logic       s_dp;
  logic [3:0] s_an;
  logic       s_ss;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] c);
    case (c)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic exp_t model_out(input logic r);
    exp_t e;
    logic [3:0] c;
    logic blank;
    e = '{seg: 7'h7F, dp: 1'b1, an: 4'hF, ss: 1'b0};
    if (!r) begin
      e.ss = (m_cnt == 0);
      if (m_cnt >= BC) begin
        c = m_bcd[m_idx*4 +: 4];
        blank = m_lzb && (m_idx >= 1);
        for (int k = m_idx; k < ND; k++)
          if (m_bcd[k*4 +: 4] != 4'd0) blank = 1'b0;
        e.an  = ~(4'b0001 << m_idx);
        e.seg = blank ? 7'h7F : ~ref_seg(c);
        e.dp  = ~m_dp[m_idx];
      end
    end
    return e;
  endfunction

  task automatic step(input logic r, input logic l, input logic [15:0] b,
                      input logic [3:0] d, input logic z);
    exp_t e;
    @(negedge clk);
    rst = r; load = l; bcd_in = b; dp_in = d; lzb_en = z;
    sb.push_back(model_out(r));
    if (r) begin
      m_cnt = 0; m_idx = 0; m_bcd = 16'hFFFF; m_dp = '0; m_lzb = 1'b0;
    end else begin
      if (m_cnt == SC - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % ND;
      end else begin
        m_cnt++;
      end
      if (l) begin
        m_bcd = b; m_dp = d; m_lzb = z;
      end
    end
    @(posedge clk);
    #1;
    s_seg = seg; s_dp = dp; s_an = an; s_ss = slot_start;
    e = sb.pop_front();
    check("seg", 32'(s_seg), 32'(e.seg));
    check("dp", 32'(s_dp), 32'(e.dp));
    check("an", 32'(s_an), 32'(e.an));
    check("slot_start", 32'(s_ss), 32'(e.ss));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
  endtask

  task automatic do_load(input logic [15:0] b, input logic [3:0] d, input logic z);
    $display("load bcd=%h dp=%b lzb=%b", b, d, z);
    step(1'b0, 1'b1, b, d, z);
  endtask

  // Steps until the sampled an equals target; a missed window counts as a miscompare.
  task automatic wait_an(input logic [3:0] target);
    int n;
    n = 0;
    do begin
      idle();
      n++;
    end while (s_an !== target && n < 80);
    check("an_wait", 32'(s_an), 32'(target));
  endtask

  task automatic spot(input string tag, input logic [3:0] a, input logic [6:0] s, input logic d);
    wait_an(a);
    $display("spot %s an=%b seg=%b dp=%b", tag, s_an, s_seg, s_dp);
    check({tag, "_seg"}, 32'(s_seg), 32'(s));
    check({tag, "_dp"}, 32'(s_dp), 32'(d));
  endtask

  initial begin
    int run;
    step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    check("rst_seg", 32'(s_seg), 32'h7F);
    check("rst_an", 32'(s_an), 32'hF);
    check("rst_ss", 32'(s_ss), 32'h0);
    step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);

    spot("idle_d0", 4'b1110, 7'h7F, 1'b1);
    run = 1;
    while (run < 40) begin
      idle();
      if (s_an !== 4'b1110) break;
      run++;
    end
    check("an_run_len", 32'(run), 32'd14);
    spot("idle_d3", 4'b0111, 7'h7F, 1'b1);

    do_load(16'h1234, 4'b0100, 1'b0);
    spot("1234_d0", 4'b1110, 7'b1001100, 1'b1);
    spot("1234_d2", 4'b1011, 7'b0010010, 1'b0);

    do_load(16'h0050, 4'b0000, 1'b1);
    spot("0050_d3", 4'b0111, 7'h7F, 1'b1);
    spot("0050_d1", 4'b1101, 7'b0100100, 1'b1);
    spot("0050_d0", 4'b1110, 7'b0000001, 1'b1);
    spot("0050_d2", 4'b1011, 7'h7F, 1'b1);

    do_load(16'h0000, 4'b0000, 1'b1);
    spot("0000z_d1", 4'b1101, 7'h7F, 1'b1);
    spot("0000z_d0", 4'b1110, 7'b0000001, 1'b1);
    do_load(16'h0000, 4'b0000, 1'b0);
    spot("0000_d3", 4'b0111, 7'b0000001, 1'b1);

    do_load(16'hABCD, 4'b0000, 1'b0);
    spot("abcd_d0", 4'b1110, 7'h7F, 1'b1);
    spot("abcd_d2", 4'b1011, 7'h7F, 1'b1);

    $display("reset with load bcd=1234");
    step(1'b1, 1'b1, 16'h1234, 4'b1111, 1'b0);
    idle();
    check("post_rst_ss", 32'(s_ss), 32'h1);
    spot("rstload_d0", 4'b1110, 7'h7F, 1'b1);

    do_load(16'h5678, 4'b0000, 1'b0);
    wait_an(4'b1011);
    $display("reset during digit-2 slot");
    step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    check("midrst_seg", 32'(s_seg), 32'h7F);
    check("midrst_an", 32'(s_an), 32'hF);
    check("midrst_dp", 32'(s_dp), 32'h1);
    idle();
    check("midrst_ss", 32'(s_ss), 32'h1);
    idle();
    idle();
    check("midrst_first_an", 32'(s_an), 32'b1110);
    spot("midrst_d1", 4'b1101, 7'h7F, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
